mod_prod_arbiter: RTL
=====================

// Module: mod_prod_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one modular-multiplier datapath (start/finished
//  handshake, operands a,b mod p) between NUM_REQ point-arithmetic engines (point add, point double).
//  Captures the winner's operands, pulses the multiplier start, waits for finished and returns the
//  product to that requester only. A watchdog aborts a hung multiplication.
// PARAMETERS
//  WIDTH          `MAX_BITS  operand/result width (ECCDefine.vh)
//  NUM_REQ        2          number of requesters (2..8)
//  TIMEOUT_CYCLES 4096       max cycles in WAIT before abort (>=2)
// PORTS
//  i_clk          in   1               single clock, rising edge
//  i_rst          in   1               asynchronous, active-high reset
//  i_req          in   NUM_REQ         level request per requester
//  i_a            in   NUM_REQ*WIDTH   operand a; requester k in [k*WIDTH +: WIDTH]
//  i_b            in   NUM_REQ*WIDTH   operand b, same packing
//  o_grant        out  NUM_REQ         one-hot owner; held from capture through RESP
//  o_done         out  NUM_REQ         one-cycle pulse to owner; o_result valid in that cycle
//  o_err          out  1               one-cycle pulse with o_done on timeout
//  o_result       out  WIDTH           last product (held until next RESP)
//  o_busy         out  1               high in any state except IDLE
//  o_mp_start     out  1               one-cycle start pulse to multiplier
//  o_mp_a/o_mp_b  out  WIDTH           captured operands, stable START..RESP
//  i_mp_result    in   WIDTH           multiplier product
//  i_mp_finished  in   1               multiplier done pulse
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, o_result=0, rr_ptr=NUM_REQ-1, so req 0 wins first.
//  All outputs are registered.
//  FSM IDLE->START->WAIT->RESP->IDLE:
//   IDLE: if |i_req, pick the first set bit searching from rr_ptr+1 with wrap. Capture its
//         i_a/i_b into o_mp_a/o_mp_b and set o_grant. Go to START.
//   START: o_mp_start=1 for exactly this cycle; clear watchdog. Go to WAIT.
//   WAIT: on i_mp_finished, latch o_result=i_mp_result and go to RESP. Else increment watchdog.
//         At TIMEOUT_CYCLES-1: o_result={WIDTH{1'b1}} (infinity sentinel), set err, go to RESP.
//   RESP: o_done[owner]=1, o_err=err. Set rr_ptr=owner. Clear o_grant at exit. Go to IDLE.
//  Latency: i_req sampled in IDLE at cycle 0 -> o_mp_start cycle 1 -> finished cycle f -> o_done cycle f+1.
//   Minimum 4 cycles from request to next grant.
//  Requester rules: hold i_req high until its o_done. Deassert by the cycle after o_done, else it is
//   re-arbitrated as a new request. Operands are sampled only at capture; later changes are ignored.
//  Requests rising outside IDLE wait; no request is lost or double-served.
//  i_mp_finished outside WAIT is ignored. Finished in START is ignored (multiplier is never faster).
//  Finished and timeout in the same cycle: finished wins, o_err=0.
//  Simultaneous requests: strict round-robin, so no starvation. Worst-case wait = (NUM_REQ-1) services.
//  Owner dropping i_req mid-operation: the operation still completes and o_done is still pulsed.
//  Reset mid-operation: the multiplier's own reset is assumed shared. No start is re-issued.
// STRUCTURE
//  Shared package/header (ECCDefine.vh): `MAX_BITS, state encodings ARB_IDLE/START/WAIT/RESP,
//   ECC_INF sentinel ({WIDTH{1'b1}}).
//  Natural sub-module: rr_pick (combinational round-robin one-hot picker: req, ptr -> onehot, idx).
//   Everything else sits in this module.
// TESTING
//  1 single: req=01, a=3,b=5 (p=7), model finishes after 10 cycles with 1
//     -> start cycle 1, o_done=01 cycle 12, o_result=1.
//  2 contention: req=11 held from reset -> grants 01 then 10.
//     Then req0 re-asserted with req1 -> grant 01 again; never two grants.
//  3 fairness: both always re-request after done, 20 services -> exactly 10 each, strictly alternating.
//  4 timeout: TIMEOUT_CYCLES=16, model never finishes -> o_err and o_done at WAIT cycle 16,
//     o_result=all ones; next request served normally.
//  5 stray finished: pulse in IDLE and in START -> no state change, no o_done.
//     Finished and timeout in the same cycle -> o_err=0.
//  6 reset: assert i_rst during WAIT -> all outputs 0 immediately. After release, req=10 granted
//     only after req0 ordering check (rr_ptr reset).

Source files
------------

// File: rtl/mod_prod_arbiter_pkg.sv
// mod_prod_arbiter_pkg: shared width default and arbiter state encodings
package mod_prod_arbiter_pkg;
  localparam int MAX_BITS = 256;
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;
endpackage

// File: rtl/mod_prod_arbiter_rr_pick.sv
// mod_prod_arbiter_rr_pick: combinational round-robin picker searching from ptr+1 with wrap
module mod_prod_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  int k;
  always_comb begin
    onehot = '0;
    idx = '0;
    k = 0;
    // walk farthest-first so the nearest requester after ptr is assigned last and wins
    for (int i = N; i >= 1; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        onehot = {{(N-1){1'b0}}, 1'b1} << k;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/mod_prod_arbiter.sv
// mod_prod_arbiter: round-robin sharing of one modular multiplier among NUM_REQ point engines,
// with a watchdog that returns the infinity sentinel on a hung multiplication.
module mod_prod_arbiter
  import mod_prod_arbiter_pkg::*;
#(
  parameter int WIDTH          = MAX_BITS,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_b,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_busy,
  output logic                     o_mp_start,
  output logic [WIDTH-1:0]         o_mp_a,
  output logic [WIDTH-1:0]         o_mp_b,
  input  logic [WIDTH-1:0]         i_mp_result,
  input  logic                     i_mp_finished
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  arb_state_t state, state_n;
  logic [IW-1:0] rr_ptr, ptr_n, owner, owner_n, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, grant_n, done_n;
  logic [TW-1:0] wd, wd_n;
  logic [WIDTH-1:0] result_n, mp_a_n, mp_b_n;
  logic start_n, err_n;
  mod_prod_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(i_req),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  always_comb begin
    state_n = state;
    ptr_n = rr_ptr;
    owner_n = owner;
    wd_n = wd;
    grant_n = o_grant;
    done_n = '0;
    err_n = 1'b0;
    start_n = 1'b0;
    result_n = o_result;
    mp_a_n = o_mp_a;
    mp_b_n = o_mp_b;
    case (state)
      ARB_IDLE: if (|i_req) begin
        state_n = ARB_START;
        grant_n = pick_oh;
        owner_n = pick_idx;
        mp_a_n = i_a[int'(pick_idx)*WIDTH +: WIDTH];
        mp_b_n = i_b[int'(pick_idx)*WIDTH +: WIDTH];
        start_n = 1'b1;
      end
      ARB_START: begin
        state_n = ARB_WAIT;
        wd_n = '0;
      end
      // finished takes priority over a coincident timeout
      ARB_WAIT: if (i_mp_finished) begin
        state_n = ARB_RESP;
        result_n = i_mp_result;
        done_n = o_grant;
      end else if (wd == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n = ARB_RESP;
        result_n = '1;
        err_n = 1'b1;
        done_n = o_grant;
      end else begin
        wd_n = wd + TW'(1);
      end
      ARB_RESP: begin
        state_n = ARB_IDLE;
        ptr_n = owner;
        grant_n = '0;
      end
      default: state_n = ARB_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= ARB_IDLE;
      rr_ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      wd <= '0;
      o_grant <= '0;
      o_done <= '0;
      o_err <= 1'b0;
      o_result <= '0;
      o_busy <= 1'b0;
      o_mp_start <= 1'b0;
      o_mp_a <= '0;
      o_mp_b <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= ptr_n;
      owner <= owner_n;
      wd <= wd_n;
      o_grant <= grant_n;
      o_done <= done_n;
      o_err <= err_n;
      o_result <= result_n;
      o_busy <= state_n != ARB_IDLE;
      o_mp_start <= start_n;
      o_mp_a <= mp_a_n;
      o_mp_b <= mp_b_n;
    end
endmodule
